// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding, index width
// and a one-hot helper.
package shared_reg_arbiter_pkg;

  localparam int MAX_N = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAPT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CAPT = 1'b1;

  // Index width for N requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    logic [MAX_N-1:0] v;
    v      = {MAX_N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: requests, data, clear,
// grants/acks and the shared register view.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import shared_reg_arbiter_pkg::*;

  localparam int IDX_W = idx_w(N);

  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic             clr;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic [W-1:0]     q;
  logic [W-1:0]     qbar;

  modport master (
    output req, wdata, clr,
    input  gnt, ack, owner, busy, q, qbar
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, ack, owner, busy, q, qbar
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan N candidates starting one past the last winner; first hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_s = IDX_W'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand_s]) begin
        valid_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and two-cycle write sequencer for one shared W-bit
// register with a synchronous clear that overrides writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shared_reg_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_w(N);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] win_q,   win_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic [N-1:0]     ack_q,   ack_d;
  logic [W-1:0]     q_q,     q_d;
  logic [W-1:0]     qbar_q;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [W-1:0]     word_s [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign word_s[i] = bus.wdata[i*W +: W];
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state logic: grant in IDLE, commit or discard in CAPT; clr always wins.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    owner_d = owner_q;
    gnt_d   = {N{1'b0}};
    ack_d   = {N{1'b0}};
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          q_d = {W{1'b0}};
        end else if (pick_valid_s) begin
          win_d   = pick_idx_s;
          gnt_d   = N'(onehot(3'(pick_idx_s)));
          state_d = ST_CAPT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPT: begin
        state_d = ST_IDLE;
        // A clear in the capture cycle drops the write; requester re-arbitrates.
        if (bus.clr) begin
          q_d = {W{1'b0}};
        end else begin
          q_d     = word_s[win_q];
          ack_d   = N'(onehot(3'(win_q)));
          owner_d = win_q;
          ptr_d   = win_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(N - 1);
      win_q   <= {IDX_W{1'b0}};
      owner_q <= {IDX_W{1'b0}};
      gnt_q   <= {N{1'b0}};
      ack_q   <= {N{1'b0}};
      q_q     <= {W{1'b0}};
      qbar_q  <= {W{1'b1}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qbar_q  <= ~q_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == ST_CAPT);
  assign bus.q     = q_q;
  assign bus.qbar  = qbar_q;

endmodule
